// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus bundle: PC request side, instruction-memory request/grant
// side and decoder side. The fetch buffer uses the master modport; the
// surrounding PC / memory / decoder environment uses the slave modport.
interface fetch_buffer_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // PC side
  logic [AW-1:0] iAddr;
  logic          pc_valid;
  logic          pc_stall;
  logic          flush;
  // instruction memory side
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  // decoder side
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  modport master (
    input  iAddr, pc_valid, flush, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
    output pc_stall, mem_req, mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output iAddr, pc_valid, flush, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
    input  pc_stall, mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer. Issues in-order memory reads for the PC address,
// remembers each granted address in a tag FIFO, and queues returned words
// with their fetch address for the decoder. A flush empties the queue and
// turns every in-flight fetch into a response to be dropped.
// Optional feature: define FETCH_BYPASS_EN to hand a response straight to
// the decoder when the queue is empty and the decoder is ready.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input logic            Clk1,
  input logic            rst,
  fetch_buffer_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic [PW-1:0] r_tag_wp;
  logic [PW-1:0] r_tag_rp;
  logic [PW-1:0] r_q_wp;
  logic [PW-1:0] r_q_rp;

  logic [AW-1:0] w_tag  [DEPTH];
  logic [AW-1:0] w_q_pc [DEPTH];
  logic [DW-1:0] w_q_inst [DEPTH];

  logic [SW-1:0] w_used;
  logic [SW-1:0] w_inflight;
  logic [CW-1:0] w_flush_discard;
  logic          w_credit;
  logic          w_mem_req;
  logic          w_grant;
  logic          w_drop;
  logic          w_accept;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  // Capacity covers queued, outstanding and still-to-be-dropped fetches so a
  // response can never find the queue full.
  assign w_used    = SW'(r_count) + SW'(r_outst) + SW'(r_discard);
  assign w_credit  = (w_used < SW'(DEPTH));
  assign w_mem_req = bus.pc_valid & w_credit & ~bus.flush & ~rst;
  assign w_grant   = w_mem_req & bus.mem_gnt;

  assign bus.mem_req  = w_mem_req;
  assign bus.mem_addr = bus.iAddr;
  assign bus.pc_stall = bus.pc_valid & ~w_grant;

  // Responses owed to a flushed fetch are dropped first; a response with
  // nothing outstanding is a protocol error and is ignored.
  assign w_empty  = (r_count == '0);
  assign w_drop   = bus.mem_rvalid & (r_discard != '0);
  assign w_accept = bus.mem_rvalid & (r_discard == '0) & (r_outst != '0);

`ifdef FETCH_BYPASS_EN
  logic [AW-1:0] w_tag_head;
  assign w_tag_head = w_tag[r_tag_rp];
  assign w_bypass   = w_accept & w_empty & bus.inst_ready & ~bus.flush;
`else
  assign w_bypass   = 1'b0;
`endif

  assign w_push = w_accept & ~w_bypass;
  assign w_pop  = ~w_empty & bus.inst_ready;

  // In-flight fetches at a flush become drops; a response arriving in the
  // flush cycle already retires one of them.
  assign w_inflight      = SW'(r_outst) + SW'(r_discard);
  assign w_flush_discard = CW'((bus.mem_rvalid && (w_inflight != '0)) ?
                               (w_inflight - SW'(1)) : w_inflight);

  // Decoder view: head entry registers, zero when empty, or the live
  // response when it is bypassed.
  always_comb begin
    bus.inst_valid = ~w_empty;
    bus.inst       = w_empty ? '0 : w_q_inst[r_q_rp];
    bus.inst_pc    = w_empty ? '0 : w_q_pc[r_q_rp];
`ifdef FETCH_BYPASS_EN
    if (w_bypass) begin
      bus.inst_valid = 1'b1;
      bus.inst       = bus.mem_rdata;
      bus.inst_pc    = w_tag_head;
    end
`endif
  end

  // Occupancy counters and FIFO pointers; flush wins over all other events.
  always_ff @(posedge Clk1 or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_outst   <= '0;
      r_discard <= '0;
      r_tag_wp  <= '0;
      r_tag_rp  <= '0;
      r_q_wp    <= '0;
      r_q_rp    <= '0;
    end else if (bus.flush) begin
      r_count   <= '0;
      r_outst   <= '0;
      r_discard <= w_flush_discard;
      r_tag_wp  <= '0;
      r_tag_rp  <= '0;
      r_q_wp    <= '0;
      r_q_rp    <= '0;
    end else begin
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_outst   <= r_outst + CW'(w_grant) - CW'(w_accept);
      r_discard <= r_discard - CW'(w_drop);
      r_tag_wp  <= r_tag_wp + PW'(w_grant);
      r_tag_rp  <= r_tag_rp + PW'(w_accept);
      r_q_wp    <= r_q_wp + PW'(w_push);
      r_q_rp    <= r_q_rp + PW'(w_pop);
    end
  end

  // One storage slot per entry: fetch-address tag plus queued {pc, word}.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [AW-1:0] r_tag_e;
    logic [AW-1:0] r_pc_e;
    logic [DW-1:0] r_inst_e;

    // Capture the granted address into the slot at the tag write pointer.
    always_ff @(posedge Clk1 or posedge rst) begin
      if (rst) begin
        r_tag_e <= '0;
      end else if (w_grant && (r_tag_wp == PW'(gi))) begin
        r_tag_e <= bus.iAddr;
      end
    end

    // Capture a returned word and its tag into the slot at the queue write pointer.
    always_ff @(posedge Clk1 or posedge rst) begin
      if (rst) begin
        r_pc_e   <= '0;
        r_inst_e <= '0;
      end else if (w_push && !bus.flush && (r_q_wp == PW'(gi))) begin
        r_pc_e   <= w_tag[r_tag_rp];
        r_inst_e <= bus.mem_rdata;
      end
    end

    assign w_tag[gi]    = r_tag_e;
    assign w_q_pc[gi]   = r_pc_e;
    assign w_q_inst[gi] = r_inst_e;
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed, table-driven bench for fetch_buffer (DEPTH=4, AW=DW=16).
// Each row drives one cycle of PC/memory/decoder inputs and checks the
// combinational outputs before the next rising edge. Rows never present a
// response to an empty queue with the decoder ready, so the expectations hold
// whether or not the bypass is built in.
module tb_fetch_buffer;
  logic Clk1;
  logic rst;

  fetch_buffer_if #(.AW(16), .DW(16)) bus ();

  fetch_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
    .Clk1 (Clk1),
    .rst  (rst),
    .bus  (bus)
  );

  initial begin
    Clk1 = 1'b0;
    forever #5 Clk1 = ~Clk1;
  end

  typedef struct {
    string       name;
    logic        pv;
    logic [15:0] addr;
    logic        fl;
    logic        gnt;
    logic        rv;
    logic [15:0] rdata;
    logic        rdy;
    logic        e_req;
    logic        e_stall;
    logic        e_iv;
    logic [15:0] e_inst;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   bad;

  task automatic add(input string nm, input logic pv, input logic [15:0] addr,
                     input logic fl, input logic gnt, input logic rv,
                     input logic [15:0] rdata, input logic rdy,
                     input logic e_req, input logic e_stall, input logic e_iv,
                     input logic [15:0] e_inst, input logic [15:0] e_pc);
    vec_t v;
    v.name = nm; v.pv = pv; v.addr = addr; v.fl = fl; v.gnt = gnt;
    v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.e_req = e_req;
    v.e_stall = e_stall; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {req,stall,iv,inst,pc,maddr}=%h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [15:0] addr, input logic fl,
                       input logic gnt, input logic rv, input logic [15:0] rdata,
                       input logic rdy);
    bus.pc_valid   = pv;
    bus.iAddr      = addr;
    bus.flush      = fl;
    bus.mem_gnt    = gnt;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rdata;
    bus.inst_ready = rdy;
  endtask

  function automatic logic [66:0] outs();
    return {bus.mem_req, bus.pc_stall, bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_addr};
  endfunction

  task automatic apply(input vec_t v);
    @(negedge Clk1);
    drive(v.pv, v.addr, v.fl, v.gnt, v.rv, v.rdata, v.rdy);
    #1;
    $display("%s pv=%b addr=%h fl=%b gnt=%b rv=%b rd=%h rdy=%b -> req=%b stall=%b iv=%b inst=%h pc=%h",
             v.name, v.pv, v.addr, v.fl, v.gnt, v.rv, v.rdata, v.rdy,
             bus.mem_req, bus.pc_stall, bus.inst_valid, bus.inst, bus.inst_pc);
    chk(v.name, outs(), {v.e_req, v.e_stall, v.e_iv, v.e_inst, v.e_pc, v.addr});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //   name   pv addr     fl gnt rv rdata    rdy  req stall iv inst     pc
    // stream, 1-cycle memory
    add("A0",  1, 16'h0000, 0, 1, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("A1",  1, 16'h0001, 0, 1, 1, 16'hA000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("A2",  1, 16'h0002, 0, 1, 1, 16'hA001, 1,  1, 0, 1, 16'hA000, 16'h0000);
    add("A3",  0, 16'h0000, 0, 0, 1, 16'hA002, 1,  0, 0, 1, 16'hA001, 16'h0001);
    add("A4",  0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'hA002, 16'h0002);
    add("A5",  0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000);
    // back-pressure: four grants fill the credit, then pops free it
    add("B0",  1, 16'hCAFE, 0, 1, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("B1",  1, 16'hCAFF, 0, 1, 1, 16'hB000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("B2",  1, 16'hCB00, 0, 1, 1, 16'hB001, 0,  1, 0, 1, 16'hB000, 16'hCAFE);
    add("B3",  1, 16'hCB01, 0, 1, 1, 16'hB002, 0,  1, 0, 1, 16'hB000, 16'hCAFE);
    add("B4",  1, 16'hCB02, 0, 1, 1, 16'hB003, 0,  0, 1, 1, 16'hB000, 16'hCAFE);
    add("B5",  1, 16'hCB02, 0, 1, 0, 16'h0000, 0,  0, 1, 1, 16'hB000, 16'hCAFE);
    add("B6",  1, 16'hCB02, 0, 1, 0, 16'h0000, 1,  0, 1, 1, 16'hB000, 16'hCAFE);
    add("B7",  1, 16'hCB02, 0, 1, 0, 16'h0000, 0,  1, 0, 1, 16'hB001, 16'hCAFF);
    add("B8",  0, 16'h0000, 0, 0, 1, 16'hB004, 1,  0, 0, 1, 16'hB001, 16'hCAFF);
    add("B9",  0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'hB002, 16'hCB00);
    add("B10", 0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'hB003, 16'hCB01);
    add("B11", 0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'hB004, 16'hCB02);
    add("B12", 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000);
    // grant withheld for three cycles
    add("C0",  1, 16'hF00D, 0, 0, 0, 16'h0000, 0,  1, 1, 0, 16'h0000, 16'h0000);
    add("C1",  1, 16'hF00D, 0, 0, 0, 16'h0000, 0,  1, 1, 0, 16'h0000, 16'h0000);
    add("C2",  1, 16'hF00D, 0, 0, 0, 16'h0000, 0,  1, 1, 0, 16'h0000, 16'h0000);
    add("C3",  1, 16'hF00D, 0, 1, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("C4",  0, 16'h0000, 0, 0, 1, 16'hC0DE, 0,  0, 0, 0, 16'h0000, 16'h0000);
    add("C5",  0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 1, 16'hC0DE, 16'hF00D);
    add("C6",  0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'hC0DE, 16'hF00D);
    add("C7",  0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000);
    // flush with 2 outstanding and 1 queued; two responses dropped
    add("D0",  1, 16'h1110, 0, 1, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("D1",  1, 16'h1111, 0, 1, 1, 16'hD000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("D2",  1, 16'h1112, 0, 1, 0, 16'h0000, 0,  1, 0, 1, 16'hD000, 16'h1110);
    add("D3",  1, 16'h5555, 1, 1, 0, 16'h0000, 1,  0, 1, 1, 16'hD000, 16'h1110);
    add("D4",  1, 16'h5555, 0, 1, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("D5",  0, 16'h0000, 0, 0, 1, 16'hDEAD, 0,  0, 0, 0, 16'h0000, 16'h0000);
    add("D6",  0, 16'h0000, 0, 0, 1, 16'hBEEF, 0,  0, 0, 0, 16'h0000, 16'h0000);
    add("D7",  0, 16'h0000, 0, 0, 1, 16'hD555, 0,  0, 0, 0, 16'h0000, 16'h0000);
    add("D8",  0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'hD555, 16'h5555);
    add("D9",  0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000);
    // flush coincident with the only response
    add("E0",  1, 16'h2222, 0, 1, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("E1",  1, 16'h3333, 1, 1, 1, 16'hEEEE, 0,  0, 1, 0, 16'h0000, 16'h0000);
    add("E2",  1, 16'h3333, 0, 1, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("E3",  0, 16'h0000, 0, 0, 1, 16'hE333, 0,  0, 0, 0, 16'h0000, 16'h0000);
    add("E4",  0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'hE333, 16'h3333);
    add("E5",  0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000);
    // stray response with nothing in flight is ignored
    add("F0",  0, 16'h0000, 0, 0, 1, 16'h9999, 0,  0, 0, 0, 16'h0000, 16'h0000);
    add("F1",  0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000);
    add("F2",  1, 16'h6666, 0, 1, 0, 16'h0000, 0,  1, 0, 0, 16'h0000, 16'h0000);
    add("F3",  0, 16'h0000, 0, 0, 1, 16'h6A6A, 0,  0, 0, 0, 16'h0000, 16'h0000);
    add("F4",  0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 0, 1, 16'h6A6A, 16'h6666);
    add("F5",  0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0000, 16'h0000);

    // reset state, with pc_valid high so the stall must follow it
    rst = 1'b1;
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    #2;
    $display("reset pv=1 -> req=%b stall=%b iv=%b", bus.mem_req, bus.pc_stall, bus.inst_valid);
    chk("reset", outs(), {1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000});
    @(negedge Clk1);
    rst = 1'b0;
    bus.pc_valid = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // asynchronous reset between edges with one entry queued, one outstanding
    begin
      vec_t r;
      r.name = "R0"; r.pv = 1; r.addr = 16'h4444; r.fl = 0; r.gnt = 1; r.rv = 0;
      r.rdata = 16'h0000; r.rdy = 0; r.e_req = 1; r.e_stall = 0; r.e_iv = 0;
      r.e_inst = 16'h0000; r.e_pc = 16'h0000;
      apply(r);
      r.name = "R1"; r.addr = 16'h4445; r.rv = 1; r.rdata = 16'h4A4A;
      apply(r);
      @(posedge Clk1);
      #2;
      chk("pre_rst_head", {34'd0, bus.inst_valid, bus.inst, bus.inst_pc},
          {34'd0, 1'b1, 16'h4A4A, 16'h4444});
      drive(1'b1, 16'h4446, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      rst = 1'b1;
      #1;
      $display("async_rst -> req=%b stall=%b iv=%b inst=%h pc=%h",
               bus.mem_req, bus.pc_stall, bus.inst_valid, bus.inst, bus.inst_pc);
      chk("async_rst", outs(), {1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h4446});
      @(negedge Clk1);
      #2;
      rst = 1'b0;
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

      r.name = "Q0"; r.pv = 1; r.addr = 16'h7777; r.gnt = 1; r.rv = 0; r.rdata = 16'h0000;
      r.rdy = 0; r.e_req = 1; r.e_stall = 0; r.e_iv = 0; r.e_inst = 16'h0000; r.e_pc = 16'h0000;
      apply(r);
      r.name = "Q1"; r.pv = 0; r.addr = 16'h0000; r.gnt = 0; r.rv = 1; r.rdata = 16'h7A7A;
      r.e_req = 0;
      apply(r);
      r.name = "Q2"; r.rv = 0; r.rdata = 16'h0000; r.rdy = 1;
      r.e_iv = 1; r.e_inst = 16'h7A7A; r.e_pc = 16'h7777;
      apply(r);
      r.name = "Q3"; r.rdy = 0; r.e_iv = 0; r.e_inst = 16'h0000; r.e_pc = 16'h0000;
      apply(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch stage sitting directly downstream of the program counter. Accepts the PC's current instruction address each cycle, issues in-order read requests to instruction memory over a request/grant interface, and queues returned instruction words together with their fetch addresses for the decoder. Back-pressures the PC via `pc_stall` when memory or queue capacity is unavailable, and discards all queued and in-flight fetches on `flush` (branch/jump redirect).

## Interface
- `DEPTH`, 4: queue entries; also the cap on queued plus outstanding fetches; power of two, 2..16.
- `AW`, 16: address width.
- `DW`, 16: instruction width.

- `Clk1`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `iAddr`  in  AW  fetch address from the PC.
- `pc_valid`  in  1  `iAddr` is a fetch request this cycle.
- `pc_stall`  out  AW-independent 1  PC must hold `iAddr` this cycle.
- `flush`  in  1  redirect; discard everything queued and in flight.
- `mem_req`  out  1  read request.
- `mem_addr`  out  AW  read address; equals `iAddr`.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid; responses return in grant order, at least 1 cycle after grant.
- `mem_rdata`  in  DW  read data.
- `inst_valid`  out  1  head entry valid.
- `inst`  out  DW  head instruction.
- `inst_pc`  out  AW  fetch address of the head instruction.
- `inst_ready`  in  1  decoder consumes the head entry.

## Operation
- `count` = valid queue entries (0..DEPTH); `outst` = granted, unreturned fetches (0..DEPTH); `discard` = responses still to drop after a flush.
- Credit: `credit` = (`count` + `outst` + `discard`) < DEPTH.
- `mem_req` = `pc_valid` & `credit` & ~`flush` & ~`rst`. `mem_addr` = `iAddr`.
- `pc_stall` = `pc_valid` & ~(`mem_req` & `mem_gnt`).
- Grant (`mem_req` & `mem_gnt`): push `iAddr` into an address tag FIFO of depth DEPTH; `outst` +1.
- Response (`mem_rvalid`): if `discard` > 0, drop and decrement `discard`; otherwise pop the tag, write {tag, `mem_rdata`} into the queue, `outst` −1, `count` +1.
- Pop (`inst_valid` & `inst_ready`): head advances, `count` −1. Push and pop in the same cycle leave `count` unchanged.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `flush`: next edge clears queue and tag FIFO (`count` = 0, `outst` = 0, pointers = 0); `discard` <= `outst` + `discard` − (1 if `mem_rvalid` that cycle, else 0). Grants in the flush cycle cannot occur because `mem_req` is low. Pops in the flush cycle are ignored.
- `mem_rvalid` with `outst` = 0 and `discard` = 0 is a protocol error; the response is ignored.
- `inst_valid` = (`count` > 0); `inst`/`inst_pc` are the head entry registers, 0 when empty.

## Timing
- Reset: `count`, `outst`, `discard`, pointers, and all queue entries = 0. Outputs: `mem_req` 0, `inst_valid` 0, `inst` 0, `inst_pc` 0; `pc_stall` = `pc_valid`.
- Request is combinational from `pc_valid`; zero-cycle stall when granted.
- With the bypass disabled, the response at edge N appears on `inst_valid` in the cycle after edge N; minimum grant-to-decode latency is 2 cycles.
- Full queue: `credit` is 0, so `mem_req` is low and `pc_stall` follows `pc_valid`. No response can ever overflow the queue.
- Reset mid-fetch: all in-flight state is lost. The memory side must be reset concurrently.

## Configuration
- `FETCH_BYPASS_EN` defined: when `count` = 0, `discard` = 0, `mem_rvalid`, and `inst_ready` are all high, `mem_rdata` and its tag drive `inst`/`inst_pc` combinationally with `inst_valid` = 1. The entry is consumed without being written, giving a 1-cycle grant-to-decode minimum.
- Not defined: every response passes through the queue registers. Outputs are purely registered.

## Test plan
- Reset then stream: `pc_valid` = 1, `mem_gnt` = 1, 1-cycle memory, addrs 0x0000, 0x0001, 0x0002 -> `inst_pc` sequence 0x0000, 0x0001, 0x0002 with matching `inst`, no `pc_stall`.
- Back-pressure: DEPTH = 4, `inst_ready` = 0, addr 0xCAFE.. -> exactly 4 grants, then `mem_req` = 0 and `pc_stall` = 1. Raising `inst_ready` pops 0xCAFE first and frees one credit per pop.
- Grant stall: `mem_gnt` = 0 for 3 cycles with `iAddr` = 0xF00D -> `pc_stall` = 1 for 3 cycles, a single grant, a single entry 0xF00D.
- Flush with 2 outstanding plus 1 queued: assert `flush` -> next cycle `inst_valid` = 0. The next 2 `mem_rvalid` are dropped, the post-flush fetch 0x5555 is the first delivered.
- Flush coincident with `mem_rvalid` (1 outstanding) -> response dropped, `discard` = 0, the next fetch 0x3333 is delivered.
- Async reset mid-stream (`rst` pulsed between edges) -> `inst_valid`, `mem_req` = 0 immediately. After release, fetch restarts cleanly with the bypass both defined and undefined.
